commit_trace_buffer: RTL and testbench

- Hardware commit monitor downstream of the single-cycle cpu core's writeback/memory signals.
- Each post-reset cycle is classified as reg-write, store, halt or other (branch/NOP), tagged with an instruction number, and pushed into a FIFO.
- The FIFO drains over a valid/ready port to a trace sink (UART bridge or bench).
- Provides cycle/instruction counters, overflow and timeout flags, and a done indication after halt drains.

---
 rtl/commit_trace_buffer_if.sv | 35 +++
 rtl/commit_trace_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Trace record port of commit_trace_buffer.
// The buffer drives the head record and rec_valid (master); the trace sink
// answers with rec_ready (slave). A record moves when rec_valid & rec_ready.
interface commit_trace_buffer_if;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_kind;
    logic [15:0] rec_inum;
    logic [15:0] rec_pc;
    logic [15:0] rec_a;
    logic [15:0] rec_b;
    logic        rec_load;

    modport master (
        output rec_valid,
        input  rec_ready,
        output rec_kind,
        output rec_inum,
        output rec_pc,
        output rec_a,
        output rec_b,
        output rec_load
    );

    modport slave (
        input  rec_valid,
        output rec_ready,
        input  rec_kind,
        input  rec_inum,
        input  rec_pc,
        input  rec_a,
        input  rec_b,
        input  rec_load
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies every committing cycle of the core
// (halt > reg-write > store > other), tags it with an instruction number and
// queues it in a DEPTH-entry FIFO that drains over a valid/ready port.
// The last FIFO slot is kept free for the halt record so it is never lost.
// Optional build macro TRACE_FILTER_NOP_EN: when defined, kind-0 (other)
// records are counted but never queued and never counted as drops.
// All outputs, including the FIFO head, are registered.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [15:0] inst,
    input  logic        reg_write,
    input  logic [3:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        hlt,
    commit_trace_buffer_if.master rec,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        timeout,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] NONHALT_LIMIT = CW'(DEPTH - 1);
    localparam logic [31:0]   CYCLE_LIMIT   = 32'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [15:0] a;
        logic [15:0] b;
        logic        load;
    } rec_t;

    rec_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    rec_t          head_r;
    logic          valid_r;
    state_t        state_r;
    logic [31:0]   cycle_count_r;
    logic [31:0]   inst_count_r;
    logic          overflow_r;
    logic [15:0]   drop_count_r;
    logic          timeout_r;
    logic          done_r;

    rec_t          new_rec_s;
    logic          run_s;
    logic          skip_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [CW-1:0] cnt_after_pop_s;
    logic [CW-1:0] count_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    rec_t          head_nxt_s;

    // Build this cycle's record with halt > reg_write > mem_write > other priority.
    always_comb begin
        new_rec_s      = '0;
        new_rec_s.inum = inst_count_r[15:0];
        new_rec_s.pc   = pc;
        if (hlt) begin
            new_rec_s.kind = 2'd3;
            new_rec_s.a    = cycle_count_r[15:0];
            new_rec_s.b    = 16'h0000;
            new_rec_s.load = 1'b0;
        end else if (reg_write) begin
            new_rec_s.kind = 2'd1;
            new_rec_s.a    = {12'h000, write_reg};
            new_rec_s.b    = write_data;
            new_rec_s.load = mem_read;
        end else if (mem_write) begin
            new_rec_s.kind = 2'd2;
            new_rec_s.a    = mem_addr;
            new_rec_s.b    = mem_data;
            new_rec_s.load = 1'b0;
        end else begin
            new_rec_s.kind = 2'd0;
            new_rec_s.a    = inst;
            new_rec_s.b    = 16'h0000;
            new_rec_s.load = 1'b0;
        end
    end

    // Decide the pop/push/drop for this cycle; the pop is accounted first so it frees a slot.
    always_comb begin
        run_s           = (state_r == ST_RUN);
        pop_s           = valid_r & rec.rec_ready;
        cnt_after_pop_s = count_r - {{AW{1'b0}}, pop_s};
`ifdef TRACE_FILTER_NOP_EN
        skip_s          = (new_rec_s.kind == 2'd0);
`else
        skip_s          = 1'b0;
`endif
        push_s = 1'b0;
        drop_s = 1'b0;
        if (!run_s) begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end else if (hlt) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (skip_s) begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end else if (cnt_after_pop_s < NONHALT_LIMIT) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end
        count_nxt_s  = cnt_after_pop_s + {{AW{1'b0}}, push_s};
        rd_ptr_nxt_s = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
    end

    // Next head record: zero when empty, bypass the new record into an empty FIFO.
    always_comb begin
        head_nxt_s = '0;
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = '0;
        end else if (cnt_after_pop_s == {CW{1'b0}}) begin
            head_nxt_s = new_rec_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage write; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_rec_s;
        end
    end

    // FIFO pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Capture state machine with its counters and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            cycle_count_r <= 32'd0;
            inst_count_r  <= 32'd0;
            overflow_r    <= 1'b0;
            drop_count_r  <= 16'd0;
            timeout_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + 32'd1;
                    inst_count_r  <= inst_count_r + 32'd1;
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                        if (drop_count_r != 16'hFFFF) begin
                            drop_count_r <= drop_count_r + 16'd1;
                        end
                    end
                    if (cycle_count_r == CYCLE_LIMIT) begin
                        timeout_r <= 1'b1;
                    end
                    if (hlt || (cycle_count_r == CYCLE_LIMIT)) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_nxt_s == {CW{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign rec.rec_valid = valid_r;
    assign rec.rec_kind  = head_r.kind;
    assign rec.rec_inum  = head_r.inum;
    assign rec.rec_pc    = head_r.pc;
    assign rec.rec_a     = head_r.a;
    assign rec.rec_b     = head_r.b;
    assign rec.rec_load  = head_r.load;

    assign cycle_count = cycle_count_r;
    assign inst_count  = inst_count_r;
    assign overflow    = overflow_r;
    assign drop_count  = drop_count_r;
    assign timeout     = timeout_r;
    assign done        = done_r;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: stimulus pushes hand-derived
// expected records into a queue, a negedge monitor pops and compares each
// record the DUT hands over. A second instance with MAX_CYCLES = 50 covers
// the timeout path.
module tb_commit_trace_buffer;

`ifdef TRACE_FILTER_NOP_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic [15:0] pc, inst, write_data, mem_addr, mem_data;
    logic        reg_write, mem_read, mem_write, hlt;
    logic [3:0]  write_reg;

    logic [31:0] cycle_count, inst_count, cycle_count2, inst_count2;
    logic        overflow, timeout, done, overflow2, timeout2, done2;
    logic [15:0] drop_count, drop_count2;

    commit_trace_buffer_if rif();
    commit_trace_buffer_if rif2();

    commit_trace_buffer #(.DEPTH(16), .MAX_CYCLES(100000)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .hlt(hlt), .rec(rif), .cycle_count(cycle_count), .inst_count(inst_count),
        .overflow(overflow), .drop_count(drop_count), .timeout(timeout), .done(done)
    );

    commit_trace_buffer #(.DEPTH(16), .MAX_CYCLES(50)) dut2 (
        .clk(clk), .rst(rst2), .pc(pc), .inst(inst), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .hlt(hlt), .rec(rif2), .cycle_count(cycle_count2), .inst_count(inst_count2),
        .overflow(overflow2), .drop_count(drop_count2), .timeout(timeout2), .done(done2)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [66:0] exp_q[$];
    int inum_m = 0;
    int pops2 = 0;

    function automatic logic [66:0] pack_rec(input logic [1:0] k, input logic [15:0] n,
                                             input logic [15:0] p, input logic [15:0] a,
                                             input logic [15:0] b, input logic l);
        return {k, n, p, a, b, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One commit cycle: drive the core signals, push the expected record if it should queue.
    task automatic commit(input logic [15:0] p, input logic [15:0] i, input logic rw,
                          input logic [3:0] wr, input logic [15:0] wd, input logic mr,
                          input logic mw, input logic [15:0] ma, input logic [15:0] md,
                          input logic h, input logic enq);
        logic [1:0]  k;
        logic [15:0] a, b;
        logic        l;
        pc = p; inst = i; reg_write = rw; write_reg = wr; write_data = wd;
        mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; hlt = h;
        l = 1'b0;
        if (h) begin
            k = 2'd3; a = inum_m[15:0]; b = 16'h0000;
        end else if (rw) begin
            k = 2'd1; a = {12'h000, wr}; b = wd; l = mr;
        end else if (mw) begin
            k = 2'd2; a = ma; b = md;
        end else begin
            k = 2'd0; a = i; b = 16'h0000;
        end
        if (enq) exp_q.push_back(pack_rec(k, inum_m[15:0], p, a, b, l));
        inum_m++;
        @(posedge clk); #1;
        reg_write = 1'b0; mem_write = 1'b0; mem_read = 1'b0; hlt = 1'b0;
    endtask

    task automatic c_reg(input logic [15:0] p, input logic [3:0] wr, input logic [15:0] wd,
                         input logic mr, input logic enq);
        commit(p, {4'h1, wr, 8'h00}, 1'b1, wr, wd, mr, 1'b0, 16'h0, 16'h0, 1'b0, enq);
    endtask

    task automatic c_halt(input logic [15:0] p);
        commit(p, 16'hF000, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc = 16'h0; inst = 16'h0; reg_write = 1'b0; write_reg = 4'h0; write_data = 16'h0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 16'h0; mem_data = 16'h0; hlt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        inum_m = 0;
        chk("rst_valid", {31'd0, rif.rec_valid}, 32'd0);
        chk("rst_data", {15'd0, rif.rec_kind, rif.rec_inum, rif.rec_a[12:0]}, 32'd0);
        chk("rst_counts", cycle_count | inst_count, 32'd0);
        chk("rst_flags", {13'd0, drop_count, overflow, timeout, done}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("sb_empty", exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor plus head-stability and idle-zero checks for the main DUT.
    initial begin
        logic [66:0] act, held;
        logic        held_v;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act = pack_rec(rif.rec_kind, rif.rec_inum, rif.rec_pc, rif.rec_a, rif.rec_b, rif.rec_load);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v && rif.rec_valid) begin
                    n_vec++;
                    if (act !== held) begin
                        n_err++;
                        $display("FAIL stable: got 0x%0h expected 0x%0h", act, held);
                    end
                end
                if (!rif.rec_valid && act != 67'd0) begin
                    n_vec++; n_err++;
                    $display("FAIL idle_zero: got 0x%0h expected 0x0", act);
                end
                if (rif.rec_valid && rif.rec_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL record: got 0x%0h expected nothing", act);
                    end else if (act !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL record: got 0x%0h expected 0x%0h", act, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
                held_v = rif.rec_valid && !rif.rec_ready;
                held = act;
            end
        end
    end

    // Monitor for the timeout instance: records must come out as inum 0,1,2... reg writes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst2 && rif2.rec_valid && rif2.rec_ready) begin
                chk("to_record", {14'd0, rif2.rec_kind, rif2.rec_inum}, {14'd0, 2'd1, pops2[15:0]});
                pops2++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst2 = 1'b1;
        rif.rec_ready = 1'b1;
        rif2.rec_ready = 1'b0;

        // Single register write followed by halt.
        do_reset();
        c_reg(16'h0000, 4'd3, 16'h00A5, 1'b0, 1'b1);
        c_halt(16'h0002);

        wait_done();

        // Store then halt; done rises exactly the cycle after the halt pops.
        do_reset();
        commit(16'h0002, 16'h2000, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1);
        c_halt(16'h0004);
        chk("done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("done_edge", {31'd0, done}, 32'd1);
        chk("inst_count_2", inst_count, 32'd2);
        chk("cycle_count_2", cycle_count, 32'd2);
        chk("sb_empty", exp_q.size(), 32'd0);

        // Overflow: 20 writes into a stalled sink, halt still lands in the reserved slot.
        do_reset();
        rif.rec_ready = 1'b0;
        for (int k = 0; k < 20; k++) c_reg(16'(2 * k), 4'(k), 16'(16'h3000 + k), 1'b0, k < 15);
        c_halt(16'h0028);
        chk("ovf_drop", {16'd0, drop_count}, 32'd5);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_inst", inst_count, 32'd21);
        chk("ovf_queued", exp_q.size(), 32'd16);
        rif.rec_ready = 1'b1;
        wait_done();

        // Backpressure: ready toggles every cycle; one load-sourced write included.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rif.rec_ready = k[0];
            c_reg(16'(16'h0100 + 2 * k), 4'(k + 1), 16'(16'h1000 + k), k == 5, 1'b1);
        end
        rif.rec_ready = 1'b0;
        c_halt(16'h0120);
        rif.rec_ready = 1'b1;
        wait_done();
        chk("bp_inst", inst_count, 32'd9);
        chk("bp_drop", {16'd0, drop_count}, 32'd0);

        // Mid-run reset with 5 queued entries.
        do_reset();
        rif.rec_ready = 1'b0;
        for (int k = 0; k < 5; k++) c_reg(16'(k), 4'(k), 16'(k), 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_valid", {31'd0, rif.rec_valid}, 32'd0);
        chk("mrst_counts", cycle_count | inst_count, 32'd0);
        do_reset();

        // Three NOP cycles; queued only when NOP filtering is off.
        for (int k = 0; k < 3; k++)
            commit(16'(16'h0200 + k), 16'(16'h0E00 + k), 1'b0, 4'h0, 16'h0, 1'b0, 1'b0,
                   16'h0, 16'h0, 1'b0, !FILT);
        chk("nop_inst", inst_count, 32'd3);
        chk("nop_valid", {31'd0, rif.rec_valid}, {31'd0, !FILT});
        rif.rec_ready = 1'b1;
        c_halt(16'h0210);
        wait_done();
        chk("nop_drop", {16'd0, drop_count}, 32'd0);

        // Timeout on the MAX_CYCLES = 50 instance, sink stalled.
        rst = 1'b1;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        reg_write = 1'b1;
        for (int k = 0; k < 60; k++) begin
            write_reg = 4'(k);
            write_data = 16'(k);
            pc = 16'(k);
            @(posedge clk); #1;
            if (k == 48) chk("to_before", {31'd0, timeout2}, 32'd0);
            if (k == 49) begin
                chk("to_set", {31'd0, timeout2}, 32'd1);
                chk("to_cycles_at", cycle_count2, 32'd50);
            end
        end
        reg_write = 1'b0;
        chk("to_cycles_frozen", cycle_count2, 32'd50);
        chk("to_inst", inst_count2, 32'd50);
        chk("to_drop", {16'd0, drop_count2}, 32'd35);
        chk("to_done_early", {31'd0, done2}, 32'd0);
        rif2.rec_ready = 1'b1;
        for (int t = 0; t < 100 && !done2; t++) begin
            @(posedge clk); #1;
        end
        chk("to_done", {31'd0, done2}, 32'd1);
        chk("to_pops", pops2, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
